// File: rtl/l2_cache_if.sv
// ----------------------------------------------------------------------------
// l2_cache_if
// Bundle of the signals between the L2 sequencing controller and its
// neighbours: the L1-side request, the datapath (comparators and way arrays)
// and physical memory.
//   master : upstream, datapath and pmem side; drives requests and array status
//   slave  : l2_cache_control; drives response, array strobes and pmem requests
// Parameters: WAYS (2 or 4), S_INDEX (set index width).
// ----------------------------------------------------------------------------
interface l2_cache_if #(
    parameter int WAYS    = 2,
    parameter int S_INDEX = 3
);
    // upstream request
    logic               mem_read;
    logic               mem_write;
    logic [31:0]        mem_byte_en;
    logic               mem_resp;
    // datapath status for the indexed set
    logic [S_INDEX-1:0] index;
    logic [WAYS-1:0]    hit_vec;
    logic [WAYS-1:0]    valid_vec;
    logic [WAYS-1:0]    dirty_vec;
    // way array control
    logic [WAYS-1:0]    way_sel;
    logic [WAYS-1:0]    tag_load;
    logic [WAYS-1:0]    dirty_load;
    logic               dirty_val;
    logic [31:0]        data_be;
    logic [WAYS-1:0]    data_we;
    logic               data_src;
    logic               addr_src;
    // physical memory
    logic               pmem_read;
    logic               pmem_write;
    logic               pmem_resp;
    // performance counters
    logic [31:0]        hit_count;
    logic [31:0]        miss_count;

    modport master (
        output mem_read, mem_write, mem_byte_en, index, hit_vec, valid_vec,
               dirty_vec, pmem_resp,
        input  mem_resp, way_sel, tag_load, dirty_load, dirty_val, data_be,
               data_we, data_src, addr_src, pmem_read, pmem_write,
               hit_count, miss_count
    );

    modport slave (
        input  mem_read, mem_write, mem_byte_en, index, hit_vec, valid_vec,
               dirty_vec, pmem_resp,
        output mem_resp, way_sel, tag_load, dirty_load, dirty_val, data_be,
               data_we, data_src, addr_src, pmem_read, pmem_write,
               hit_count, miss_count
    );
endinterface

// File: rtl/l2_cache_control.sv
// ----------------------------------------------------------------------------
// l2_cache_control
// Sequencing FSM for a set-associative L2 array. Serves one upstream request
// at a time: hit check, dirty-victim writeback, line fetch, then a replay of
// the compare which is guaranteed to hit. Owns the per-set tree-PLRU bits and
// the victim choice.
// Ports:
//   clk  - clock
//   rst  - synchronous reset, active-low (0 = reset)
//   bus  - l2_cache_if.slave: upstream request/response, datapath status,
//          way strobes, pmem handshake, performance counters
// Optional feature: define L2_PERF_CNT_EN to build saturating hit/miss
// counters; otherwise hit_count and miss_count are tied to 0.
// ----------------------------------------------------------------------------
module l2_cache_control #(
    parameter int WAYS    = 2,
    parameter int S_INDEX = 3
) (
    input  logic        clk,
    input  logic        rst,
    l2_cache_if.slave   bus
);
    localparam int NUM_SETS = 2 ** S_INDEX;
    localparam int WIDX     = $clog2(WAYS);
    localparam int PLRU_W   = WAYS - 1;

    typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, FETCH} state_t;

    state_t            state;
    logic [PLRU_W-1:0] plru [NUM_SETS];
    logic [WIDX-1:0]   victim;
    logic              pmem_read_q;
    logic              pmem_write_q;
    logic              addr_src_q;

    // Tree PLRU: bit0 is the root (0 = left pair), bit1/bit2 pick within the
    // left/right pair. For two ways bit0 directly names the victim.
    function automatic logic [WIDX-1:0] plru_victim(input logic [PLRU_W-1:0] bits);
        logic [2:0] b;
        b = 3'(bits);
        if (WAYS == 2) return WIDX'(b[0]);
        return b[0] ? WIDX'({1'b1, b[2]}) : WIDX'({1'b0, b[1]});
    endfunction

    // Point every tree node on the path to the accessed way away from it.
    function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] bits,
                                                     input logic [WIDX-1:0]   way);
        logic [2:0] b;
        logic [1:0] w;
        b = 3'(bits);
        w = 2'(way);
        if (WAYS == 2) begin
            b[0] = ~w[0];
        end else begin
            b[0] = ~w[1];
            if (w[1]) b[2] = ~w[0];
            else      b[1] = ~w[0];
        end
        return PLRU_W'(b);
    endfunction

    function automatic logic [WIDX-1:0] lowest(input logic [WAYS-1:0] v);
        logic [WIDX-1:0] r;
        r = '0;
        for (int i = WAYS - 1; i >= 0; i--) if (v[i]) r = WIDX'(i);
        return r;
    endfunction

    logic            req;
    logic            hit;
    logic [WIDX-1:0] hit_way;
    logic [WIDX-1:0] miss_victim;
    logic            miss_dirty;
    logic [WAYS-1:0] hit_oh;
    logic [WAYS-1:0] victim_oh;

    // A simultaneous read and write is served as a write.
    assign req         = bus.mem_read | bus.mem_write;
    assign hit         = |bus.hit_vec;
    assign hit_way     = lowest(bus.hit_vec);
    assign miss_victim = (~bus.valid_vec != '0) ? lowest(~bus.valid_vec)
                                                : plru_victim(plru[bus.index]);
    assign miss_dirty  = bus.valid_vec[miss_victim] & bus.dirty_vec[miss_victim];
    assign hit_oh      = WAYS'(1) << hit_way;
    assign victim_oh   = WAYS'(1) << victim;

    // NOTE: non-blocking assignments for all state so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            victim       <= '0;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            addr_src_q   <= 1'b0;
            // NOTE: the PLRU store is cleared on reset because a known victim
            // order after reset is part of the block's behaviour.
            for (int s = 0; s < NUM_SETS; s++) plru[s] <= '0;
        end else begin
            case (state)
                IDLE: if (req) state <= COMPARE;
                COMPARE: begin
                    if (!req) begin
                        // requester went away during the miss; drop the replay
                        state <= IDLE;
                    end else if (hit) begin
                        plru[bus.index] <= plru_touch(plru[bus.index], hit_way);
                        state           <= IDLE;
                    end else begin
                        victim <= miss_victim;
                        if (miss_dirty) begin
                            state        <= WRITEBACK;
                            pmem_write_q <= 1'b1;
                            addr_src_q   <= 1'b1;
                        end else begin
                            state       <= FETCH;
                            pmem_read_q <= 1'b1;
                        end
                    end
                end
                WRITEBACK: if (bus.pmem_resp) begin
                    state        <= FETCH;
                    pmem_write_q <= 1'b0;
                    addr_src_q   <= 1'b0;
                    pmem_read_q  <= 1'b1;
                end
                FETCH: if (bus.pmem_resp) begin
                    state       <= COMPARE;
                    pmem_read_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.pmem_read  = pmem_read_q;
    assign bus.pmem_write = pmem_write_q;
    assign bus.addr_src   = addr_src_q;

    // Strobes that must land in the same cycle as hit_vec / pmem_resp are
    // decoded here; they are held off while reset is asserted.
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves one
        // unassigned and no latch is inferred.
        bus.mem_resp   = 1'b0;
        bus.way_sel    = '0;
        bus.tag_load   = '0;
        bus.dirty_load = '0;
        bus.dirty_val  = 1'b0;
        bus.data_be    = '0;
        bus.data_we    = '0;
        bus.data_src   = 1'b0;
        if (rst) begin
            case (state)
                COMPARE: if (req && hit) begin
                    bus.mem_resp = 1'b1;
                    bus.way_sel  = hit_oh;
                    if (bus.mem_write) begin
                        bus.data_we    = hit_oh;
                        bus.data_be    = bus.mem_byte_en;
                        bus.dirty_load = hit_oh;
                        bus.dirty_val  = 1'b1;
                    end
                end
                WRITEBACK: bus.way_sel = victim_oh;
                FETCH: if (bus.pmem_resp) begin
                    bus.tag_load   = victim_oh;
                    bus.data_we    = victim_oh;
                    bus.data_be    = 32'hFFFF_FFFF;
                    bus.data_src   = 1'b1;
                    bus.dirty_load = victim_oh;
                end
                default: ;
            endcase
        end
    end

`ifdef L2_PERF_CNT_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
    logic        replay;

    // replay marks the compare that follows a fill so it is not counted as a hit
    always_ff @(posedge clk) begin
        if (!rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
            replay   <= 1'b0;
        end else begin
            if (state == FETCH && bus.pmem_resp) replay <= 1'b1;
            else if (state == COMPARE)           replay <= 1'b0;
            if (state == COMPARE && req && hit && !replay && hit_cnt != 32'hFFFF_FFFF)
                hit_cnt <= hit_cnt + 32'd1;
            if (state == COMPARE && req && !hit && miss_cnt != 32'hFFFF_FFFF)
                miss_cnt <= miss_cnt + 32'd1;
        end
    end

    assign bus.hit_count  = hit_cnt;
    assign bus.miss_count = miss_cnt;
`else
    assign bus.hit_count  = '0;
    assign bus.miss_count = '0;
`endif

endmodule
